// File: rtl/fsm_seq_monitor.sv
// Run-time integrity monitor for the 2-bit sequencer code stream (0-1-2-3-0 / 0-1-3-0).
// Define SEQ_MON_HOLD_EN to accept a repeated code in LOCK as a legal stall.
module fsm_seq_monitor #(
  parameter int CNT_W     = 8,
  parameter int ERR_LIMIT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [1:0]       code,
  input  logic             clr,
  output logic             locked,
  output logic             frame_done,
  output logic             bypass_seen,
  output logic             seq_err,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] bypass_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [3:0]       LIMIT   = 4'(ERR_LIMIT);

  state_t     state, state_nxt;
  logic [1:0] last, last_nxt;
  logic [3:0] bad_run, bad_run_nxt, bad_run_inc;
  logic       frame_nxt, bypass_nxt, err_nxt;
  logic       legal, hold;

  always_comb begin
    legal = 1'b0;
    case ({last, code})
      4'b0001, 4'b0110, 4'b0111, 4'b1011, 4'b1100: legal = 1'b1;
      default:                                     legal = 1'b0;
    endcase
  end

`ifdef SEQ_MON_HOLD_EN
  assign hold = (last == code);
`else
  assign hold = 1'b0;
`endif

  assign bad_run_inc = bad_run + 4'd1;

  always_comb begin
    state_nxt   = state;
    last_nxt    = last;
    bad_run_nxt = bad_run;
    frame_nxt   = 1'b0;
    bypass_nxt  = 1'b0;
    err_nxt     = 1'b0;
    if (in_valid) begin
      case (state)
        HUNT: begin
          if (code == 2'd0) begin
            state_nxt   = LOCK;
            last_nxt    = 2'd0;
            bad_run_nxt = 4'd0;
          end
        end
        LOCK: begin
          if (hold) begin
            bad_run_nxt = 4'd0;
          end else if (legal) begin
            last_nxt    = code;
            bad_run_nxt = 4'd0;
            bypass_nxt  = (last == 2'd1) && (code == 2'd3);
            frame_nxt   = (last == 2'd3);
          end else begin
            // Resync to the observed code so one glitch costs one error.
            err_nxt  = 1'b1;
            last_nxt = code;
            if (bad_run_inc == LIMIT) begin
              state_nxt   = HUNT;
              bad_run_nxt = 4'd0;
            end else begin
              bad_run_nxt = bad_run_inc;
            end
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
    if (clr) bad_run_nxt = 4'd0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= HUNT;
      last    <= 2'd0;
      bad_run <= 4'd0;
    end else begin
      state   <= state_nxt;
      last    <= last_nxt;
      bad_run <= bad_run_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_done  <= 1'b0;
      bypass_seen <= 1'b0;
      seq_err     <= 1'b0;
      frame_cnt   <= '0;
      bypass_cnt  <= '0;
      err_cnt     <= '0;
    end else begin
      frame_done  <= frame_nxt;
      bypass_seen <= bypass_nxt;
      seq_err     <= err_nxt;
      if (clr) begin
        frame_cnt  <= '0;
        bypass_cnt <= '0;
        err_cnt    <= '0;
      end else begin
        if (frame_nxt && frame_cnt != CNT_MAX)   frame_cnt  <= frame_cnt + 1'b1;
        if (bypass_nxt && bypass_cnt != CNT_MAX) bypass_cnt <= bypass_cnt + 1'b1;
        if (err_nxt && err_cnt != CNT_MAX)       err_cnt    <= err_cnt + 1'b1;
      end
    end
  end

  assign locked = (state == LOCK);

endmodule
